systolic_array: RTL and testbench

SYSTOLIC_ARRAY -- requirements
Module: systolic_array

---
 rtl/systolic_array.sv | 140 ++++++++++++++
 tb/tb_systolic_array.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array.sv
// ============================================================================
// systolic_array
// ----------------------------------------------------------------------------
// A 4x4 output-stationary systolic multiply array. Operands flow west->east
// (a) and north->south (b) through per-PE pipeline registers. Each PE holds
// one 32-bit running sum. A skewed feed therefore produces C = A x B in the
// accumulators.
//
// Ports
//   clk     in   1    sole clock; all state changes on the rising edge
//   rst_n   in   1    synchronous reset, ACTIVE-HIGH despite the name:
//                     1 at a rising edge clears every register
//   a       in   64   west lanes; lane i = a[16*i+15:16*i] enters row i
//   b       in   64   north lanes; lane j = b[16*j+15:16*j] enters column j
//   result  out  512  C[i][j] = result[32*(4*i+j)+31 : 32*(4*i+j)]
//
// Feeding C = A x B (edges t = 0..9 after reset release):
//   a lane i = A[i][t-i], b lane j = B[t-j][j], and 0 outside 0..3.
//   PE(i,j) then sees A[i][k] and B[k][j] together at edge k+i+j. The last
//   term lands in PE(3,3) at edge 9, so result is complete after edge 9.
//
// The array has no valid, ready or busy signalling. Every PE does a MAC on
// every cycle out of reset. Driving zeros holds the sums. A second product
// needs a reset first, because otherwise it adds onto the previous sums.
// ============================================================================

// ----------------------------------------------------------------------------
// systolic_array_pe
//   One processing element. It registers the operands for its east and
//   south neighbours, and it accumulates their product modulo 2^32.
//
// Ports
//   clk    in   1   clock
//   rst    in   1   synchronous active-high clear; it wins over the MAC
//   a_in   in   16  operand arriving from the west
//   b_in   in   16  operand arriving from the north
//   a_out  out  16  registered a_in, passed east
//   b_out  out  16  registered b_in, passed south
//   acc    out  32  running sum of a_in*b_in
// ----------------------------------------------------------------------------
module systolic_array_pe (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic [15:0] a_out,
    output logic [15:0] b_out,
    output logic [31:0] acc
);

    // Both operands are widened before the multiply, so the full 32-bit
    // unsigned product is kept.
    logic [31:0] product;

    assign product = {16'd0, a_in} * {16'd0, b_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out <= 16'd0;
            b_out <= 16'd0;
            acc   <= 32'd0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + product;   // wraps modulo 2^32, by design
        end
    end

endmodule

// ----------------------------------------------------------------------------
// systolic_array (top)
// ----------------------------------------------------------------------------
module systolic_array (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    output logic [511:0] result
);

    localparam int N = 4;

    // rst_n is active-high. The name is kept to match the surrounding
    // system wiring.
    logic rst;

    assign rst = rst_n;

    // Per-PE operand inputs and registered operand outputs.
    logic [15:0] a_in  [N][N];
    logic [15:0] b_in  [N][N];
    logic [15:0] a_reg [N][N];
    logic [15:0] b_reg [N][N];
    logic [31:0] acc   [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col

            // West edge takes the input lane directly. Interior PEs take
            // the a-register of their west neighbour.
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = a[16*i +: 16];
            end else begin : g_a_link
                assign a_in[i][j] = a_reg[i][j-1];
            end

            // North edge takes the input lane directly. Interior PEs take
            // the b-register of their north neighbour.
            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = b[16*j +: 16];
            end else begin : g_b_link
                assign b_in[i][j] = b_reg[i-1][j];
            end

            systolic_array_pe u_pe (
                .clk   (clk),
                .rst   (rst),
                .a_in  (a_in[i][j]),
                .b_in  (b_in[i][j]),
                .a_out (a_reg[i][j]),
                .b_out (b_reg[i][j]),
                .acc   (acc[i][j])
            );

            // Outputs come straight from the accumulators, with no extra
            // output register stage.
            assign result[32*(N*i+j) +: 32] = acc[i][j];
        end
    end

    // The east column's a-registers and the south row's b-registers feed no
    // neighbour. They are kept so that every PE is identical, and they are
    // collected here so that their lack of a load is explicit.
    logic [127:0] unused_edge_regs;

    assign unused_edge_regs = {a_reg[0][3], a_reg[1][3], a_reg[2][3], a_reg[3][3],
                               b_reg[3][0], b_reg[3][1], b_reg[3][2], b_reg[3][3]};

endmodule

// File: tb/tb_systolic_array.sv
// Bench for systolic_array. A matrix-level reference model (C += A*B, using
// plain arithmetic modulo 2^32) supplies the expected values through exp_q.
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge that follows each rising edge.
module tb_systolic_array;

    logic         clk;
    logic         rst_n;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [511:0] result;

    int vectors;
    int miscompares;

    logic [15:0] mat_a [4][4];
    logic [15:0] mat_b [4][4];
    logic [31:0] exp_c [4][4];
    logic [31:0] exp_q [$];

    systolic_array dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .result (result)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                exp_c[i][j] = 32'd0;
    endtask

    // Adds the product of the current mat_a and mat_b onto the expected sums.
    task automatic model_add();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++)
                    exp_c[i][j] = exp_c[i][j] + 32'(mat_a[i][k]) * 32'(mat_b[k][j]);
    endtask

    task automatic queue_expected();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                exp_q.push_back(exp_c[i][j]);
    endtask

    // ---------------- matrix setters ----------------
    task automatic set_known_ab();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                mat_a[i][j] = 16'(4*i + j + 1);
                mat_b[i][j] = 16'(4*i + j + 1);
            end
    endtask

    task automatic set_zero_ab();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                mat_a[i][j] = 16'd0;
                mat_b[i][j] = 16'd0;
            end
    endtask

    task automatic set_random_ab();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                mat_a[i][j] = 16'($urandom_range(0, 65535));
                mat_b[i][j] = 16'($urandom_range(0, 65535));
            end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // A single reset edge with random operands, which the DUT must ignore.
    task automatic do_reset();
        rst_n = 1'b1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        step();
        rst_n = 1'b0;
        a = 64'd0;
        b = 64'd0;
        model_clear();
    endtask

    // Skewed lanes for input edge t.
    task automatic drive_edge(input int t);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = t - i;
            a[16*i +: 16] = (k >= 0 && k <= 3) ? mat_a[i][k] : 16'd0;
            b[16*i +: 16] = (k >= 0 && k <= 3) ? mat_b[k][i] : 16'd0;
        end
    endtask

    task automatic feed();
        for (int t = 0; t < 10; t++) begin
            drive_edge(t);
            step();
        end
        a = 64'd0;
        b = 64'd0;
        model_add();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            step();
        end
        do_reset();
        queue_expected();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [31:0] got, want;
                want = exp_q.pop_front();
                got = result[32*(4*i+j) +: 32];
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL reset C[%0d][%0d] got %h want %h", i, j, got, want);
                end
            end
    endtask

    // The first edge out of reset already performs a MAC. Only PE(0,0) sees
    // two live operands, because every other PE has a zero register input.
    task automatic test_first_mac();
        logic [15:0] x, y;
        do_reset();
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        x = a[15:0];
        y = b[15:0];
        step();
        a = 64'd0;
        b = 64'd0;
        exp_c[0][0] = 32'(x) * 32'(y);
        queue_expected();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [31:0] got, want;
                want = exp_q.pop_front();
                got = result[32*(4*i+j) +: 32];
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL first_mac C[%0d][%0d] got %h want %h", i, j, got, want);
                end
            end
    endtask

    task automatic test_known();
        do_reset();
        set_known_ab();
        feed();
        queue_expected();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [31:0] got, want;
                want = exp_q.pop_front();
                got = result[32*(4*i+j) +: 32];
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL known C[%0d][%0d] got %h want %h", i, j, got, want);
                end
            end
    endtask

    task automatic test_identity();
        do_reset();
        set_known_ab();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                mat_a[i][j] = (i == j) ? 16'd1 : 16'd0;
        feed();
        queue_expected();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [31:0] got, want;
                want = exp_q.pop_front();
                got = result[32*(4*i+j) +: 32];
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL identity C[%0d][%0d] got %h want %h", i, j, got, want);
                end
            end
    endtask

    // Boundary values. Case 0 is a single 0xFFFF*0xFFFF term. Case 1 is two
    // such terms, which wrap modulo 2^32 to 0xFFFC0002.
    task automatic test_extremes();
        for (int c = 0; c < 2; c++) begin
            do_reset();
            set_zero_ab();
            mat_a[0][0] = 16'hFFFF;
            mat_b[0][0] = 16'hFFFF;
            if (c == 1) begin
                mat_a[0][1] = 16'hFFFF;
                mat_b[1][0] = 16'hFFFF;
            end
            feed();
            queue_expected();
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    logic [31:0] got, want;
                    want = exp_q.pop_front();
                    got = result[32*(4*i+j) +: 32];
                    vectors++;
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL extreme%0d C[%0d][%0d] got %h want %h", c, i, j, got, want);
                    end
                end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            set_random_ab();
            feed();
            queue_expected();
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    logic [31:0] got, want;
                    want = exp_q.pop_front();
                    got = result[32*(4*i+j) +: 32];
                    vectors++;
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL random%0d C[%0d][%0d] got %h want %h", r, i, j, got, want);
                    end
                end
        end
    endtask

    // Two feeds back to back with no reset between them. The second product
    // adds onto the first.
    task automatic test_back_to_back();
        do_reset();
        set_random_ab();
        feed();
        set_random_ab();
        feed();
        queue_expected();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [31:0] got, want;
                want = exp_q.pop_front();
                got = result[32*(4*i+j) +: 32];
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL back_to_back C[%0d][%0d] got %h want %h", i, j, got, want);
                end
            end
    endtask

    // Reset lands on edge 5 of a feed, and then a complete fresh feed runs.
    task automatic test_mid_reset();
        do_reset();
        set_random_ab();
        for (int t = 0; t < 5; t++) begin
            drive_edge(t);
            step();
        end
        drive_edge(5);
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        model_clear();
        set_known_ab();
        feed();
        queue_expected();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [31:0] got, want;
                want = exp_q.pop_front();
                got = result[32*(4*i+j) +: 32];
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL mid_reset C[%0d][%0d] got %h want %h", i, j, got, want);
                end
            end
    endtask

    // Holding zero inputs keeps the result. One reset edge then clears it.
    task automatic test_hold();
        do_reset();
        set_known_ab();
        feed();
        for (int n = 0; n < 20; n++)
            step();
        queue_expected();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [31:0] got, want;
                want = exp_q.pop_front();
                got = result[32*(4*i+j) +: 32];
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL hold C[%0d][%0d] got %h want %h", i, j, got, want);
                end
            end
        do_reset();
        queue_expected();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [31:0] got, want;
                want = exp_q.pop_front();
                got = result[32*(4*i+j) +: 32];
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL hold_reset C[%0d][%0d] got %h want %h", i, j, got, want);
                end
            end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b1;
        a = 64'd0;
        b = 64'd0;
        model_clear();
        step();
        step();
        test_reset();
        test_first_mac();
        test_known();
        test_identity();
        test_extremes();
        test_random();
        test_back_to_back();
        test_mid_reset();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
